// File: rtl/memory_access_pkg.sv
// Shared definitions for the MEM pipeline stage: access-width encodings,
// default datapath width and byte-lane enable patterns.
// No logic; imported by memory_access and data_memory.
package memory_access_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_LANE     = 4;    // byte lanes per data word

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_RSVD = 2'b10,            // decoded exactly like WORD
        WIDTH_WORD = 2'b11
    } width_e;

    localparam logic [NB_LANE-1:0] LANE_B0      = 4'b0001;
    localparam logic [NB_LANE-1:0] LANE_LO_HALF = 4'b0011;
    localparam logic [NB_LANE-1:0] LANE_HI_HALF = 4'b1100;
    localparam logic [NB_LANE-1:0] LANE_ALL     = 4'b1111;

endpackage

// File: rtl/memory_access_data_memory.sv
// Data memory: 2^NB_ADDR words, byte-lane synchronous write, combinational read,
// registered debug read (1 cycle). Synchronous clear of the whole array on i_rst.
// No backpressure; the caller gates i_we while the pipeline is frozen.
//   clk, i_rst            clock, synchronous active-high reset/clear
//   i_we, i_addr, i_wdata byte-lane write port
//   o_rdata               combinational read of i_addr
//   i_dbg_addr/o_dbg_data registered debug read port
module data_memory
    import memory_access_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_LANE-1:0] i_we,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_wdata,
    output logic [NB_DATA-1:0] o_rdata,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];

    assign o_rdata = mem[i_addr];

    // Reset clears the array and wins over any store sampled on the same edge.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < NB_LANE; b++) begin
                if (i_we[b]) begin
                    mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Debug read samples the pre-store contents when the same word is written.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_dbg_data <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end

endmodule

// File: rtl/memory_access.sv
// MIPS MEM stage: byte/half/word loads and stores on internal data memory, MEM/WB register.
// Latency: load data and control registered at the sampling edge (1 cycle); debug read 1 cycle.
// Backpressure: i_stall/i_halt hold every MEM/WB output and suppress stores; debug port keeps running.
//   inputs : EX/MEM fields (i_result, i_data4Mem, i_write_reg, controls), i_dbg_addr
//   outputs: MEM/WB fields (o_mem2reg, o_regWrite, o_write_reg, o_read_data, o_result,
//            o_misaligned), o_dbg_data
module memory_access
    import memory_access_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [4:0]         i_write_reg,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [4:0]         o_write_reg,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_dbg_data
);

    logic               frozen;
    logic [1:0]         lane;
    logic [NB_ADDR-1:0] word_addr;
    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic               misaligned;
    logic [NB_LANE-1:0] lane_en;
    logic [NB_LANE-1:0] we;
    logic [NB_DATA-1:0] wdata;
    logic [NB_DATA-1:0] load_val;
    logic               unused_addr_hi;

    assign frozen    = i_stall | i_halt;
    assign lane      = i_result[1:0];
    assign word_addr = i_result[NB_ADDR+1:2];
    // Address bits above the memory are deliberately ignored.
    assign unused_addr_hi = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign ld_byte = rd_word[{lane, 3'b000} +: 8];
    assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        misaligned = 1'b0;
        lane_en    = LANE_ALL;
        wdata      = i_data4Mem;
        load_val   = rd_word;
        case (i_width)
            WIDTH_BYTE: begin
                lane_en  = LANE_B0 << lane;
                wdata    = {NB_LANE{i_data4Mem[7:0]}};
                load_val = {{(NB_DATA-8){i_sign_flag & ld_byte[7]}}, ld_byte};
            end
            WIDTH_HALF: begin
                misaligned = lane[0];
                lane_en    = lane[1] ? LANE_HI_HALF : LANE_LO_HALF;
                wdata      = {2{i_data4Mem[15:0]}};
                load_val   = {{(NB_DATA-16){i_sign_flag & ld_half[15]}}, ld_half};
            end
            default: begin
                misaligned = (lane != 2'b00);
            end
        endcase
        // The misalignment flag only means something for an actual memory access.
        misaligned = misaligned & (i_memRead | i_memWrite);
        we = (i_memWrite && !misaligned && !frozen) ? lane_en : '0;
    end

    data_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_data_memory (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_we       (we),
        .i_addr     (word_addr),
        .i_wdata    (wdata),
        .o_rdata    (rd_word),
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data)
    );

    // MEM/WB register; load data is the pre-store word when read and write coincide.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_write_reg  <= '0;
            o_read_data  <= '0;
            o_result     <= '0;
            o_misaligned <= 1'b0;
        end else if (!frozen) begin
            o_mem2reg    <= i_mem2reg;
            o_regWrite   <= i_regWrite & ~misaligned;
            o_write_reg  <= i_write_reg;
            o_read_data  <= (i_memRead && !misaligned) ? load_val : '0;
            o_result     <= i_result;
            o_misaligned <= misaligned;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 8;

    logic               clk = 1'b0;
    logic               i_rst;
    logic               i_stall;
    logic               i_halt;
    logic [NB_DATA-1:0] i_result;
    logic [NB_DATA-1:0] i_data4Mem;
    logic [4:0]         i_write_reg;
    logic               i_mem2reg;
    logic               i_memRead;
    logic               i_memWrite;
    logic               i_regWrite;
    logic [1:0]         i_width;
    logic               i_sign_flag;
    logic [NB_ADDR-1:0] i_dbg_addr;
    logic               o_mem2reg;
    logic               o_regWrite;
    logic [4:0]         o_write_reg;
    logic [NB_DATA-1:0] o_read_data;
    logic [NB_DATA-1:0] o_result;
    logic               o_misaligned;
    logic [NB_DATA-1:0] o_dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_access #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_stall      (i_stall),
        .i_halt       (i_halt),
        .i_result     (i_result),
        .i_data4Mem   (i_data4Mem),
        .i_write_reg  (i_write_reg),
        .i_mem2reg    (i_mem2reg),
        .i_memRead    (i_memRead),
        .i_memWrite   (i_memWrite),
        .i_regWrite   (i_regWrite),
        .i_width      (i_width),
        .i_sign_flag  (i_sign_flag),
        .i_dbg_addr   (i_dbg_addr),
        .o_mem2reg    (o_mem2reg),
        .o_regWrite   (o_regWrite),
        .o_write_reg  (o_write_reg),
        .o_read_data  (o_read_data),
        .o_result     (o_result),
        .o_misaligned (o_misaligned),
        .o_dbg_data   (o_dbg_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one EX/MEM instruction, clock it in, and settle past the edge.
    task automatic op(input logic rd, input logic wr, input logic [1:0] w, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [4:0] wreg, input logic regw, input logic m2r);
        i_memRead   = rd;
        i_memWrite  = wr;
        i_width     = w;
        i_sign_flag = sgn;
        i_result    = addr;
        i_data4Mem  = data;
        i_write_reg = wreg;
        i_regWrite  = regw;
        i_mem2reg   = m2r;
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] data);
        op(1'b0, 1'b1, 2'b11, 1'b0, addr, data, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [1:0] w, input logic sgn, input logic [31:0] addr);
        op(1'b1, 1'b0, w, sgn, addr, 32'h0, 5'd9, 1'b1, 1'b1);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_halt = 1'b0; i_dbg_addr = '0;
        idle();
        idle();
        chk("rst_result",   o_result, 32'h0);
        chk("rst_read",     o_read_data, 32'h0);
        chk("rst_ctrl",     {27'h0, o_mem2reg, o_regWrite, o_misaligned, 2'b00}, 32'h0);
        chk("rst_wreg",     {27'h0, o_write_reg}, 32'h0);
        chk("rst_dbg",      o_dbg_data, 32'h0);
        i_rst = 1'b0;
        for (int w = 0; w < 4; w++) begin
            i_dbg_addr = w[NB_ADDR-1:0];
            idle();
            chk("dbg_cleared", o_dbg_data, 32'h0);
        end

        // Word store then load
        sw(32'h10, 32'hDEADBEEF);
        chk("sw_regwrite", {31'h0, o_regWrite}, 32'h0);
        chk("sw_result",   o_result, 32'h10);
        ld(2'b11, 1'b0, 32'h10);
        chk("lw_data",     o_read_data, 32'hDEADBEEF);
        chk("lw_regwrite", {31'h0, o_regWrite}, 32'h1);
        chk("lw_wreg",     {27'h0, o_write_reg}, 32'd9);
        chk("lw_mem2reg",  {31'h0, o_mem2reg}, 32'h1);

        // Byte store into a zeroed word, signed/unsigned byte loads
        sw(32'h10, 32'h0);
        op(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h12345680, 5'd0, 1'b0, 1'b0);
        ld(2'b00, 1'b1, 32'h11);
        chk("lb_sext",  o_read_data, 32'hFFFFFF80);
        ld(2'b00, 1'b0, 32'h11);
        chk("lbu_zext", o_read_data, 32'h00000080);
        ld(2'b11, 1'b1, 32'h10);
        chk("lw_after_sb", o_read_data, 32'h00008000);

        // Half store, aligned/misaligned accesses
        op(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD1234, 5'd0, 1'b0, 1'b0);
        ld(2'b01, 1'b1, 32'h22);
        chk("lh_data", o_read_data, 32'h00001234);
        chk("lh_misal", {31'h0, o_misaligned}, 32'h0);
        ld(2'b01, 1'b1, 32'h21);
        chk("lh_mis_flag", {31'h0, o_misaligned}, 32'h1);
        chk("lh_mis_data", o_read_data, 32'h0);
        chk("lh_mis_regw", {31'h0, o_regWrite}, 32'h0);
        chk("lh_mis_result", o_result, 32'h21);
        sw(32'h23, 32'hFFFFFFFF);
        chk("sw_mis_flag", {31'h0, o_misaligned}, 32'h1);
        ld(2'b11, 1'b0, 32'h20);
        chk("sw_mis_nowrite", o_read_data, 32'h12340000);
        chk("misal_cleared", {31'h0, o_misaligned}, 32'h0);
        ld(2'b00, 1'b1, 32'h23);
        chk("lb_lane3", o_read_data, 32'h00000012);
        op(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 5'd9, 1'b1, 1'b1);
        chk("rsvd_misal", {31'h0, o_misaligned}, 32'h1);

        // Stall during a store: nothing written, outputs held
        op(1'b0, 1'b0, 2'b11, 1'b0, 32'h99, 32'h0, 5'd7, 1'b1, 1'b0);
        chk("alu_result", o_result, 32'h99);
        i_stall    = 1'b1;
        i_dbg_addr = 8'd12;
        for (int c = 0; c < 3; c++) begin
            sw(32'h30, 32'h55AA55AA);
            chk("stall_result", o_result, 32'h99);
            chk("stall_regw",   {27'h0, o_regWrite, o_write_reg[3:0]}, {27'h0, 1'b1, 4'd7});
            chk("stall_nowrite", o_dbg_data, 32'h0);
        end
        i_stall = 1'b0;
        sw(32'h30, 32'h55AA55AA);
        chk("unstall_result", o_result, 32'h30);
        ld(2'b11, 1'b0, 32'h30);
        chk("unstall_load", o_read_data, 32'h55AA55AA);
        chk("unstall_dbg",  o_dbg_data, 32'h55AA55AA);

        // Halt freezes like stall
        i_halt = 1'b1;
        ld(2'b11, 1'b0, 32'h10);
        chk("halt_result", o_result, 32'h30);
        chk("halt_read",   o_read_data, 32'h55AA55AA);
        i_halt = 1'b0;

        // Debug read of a word stored on the same edge sees the old value
        i_dbg_addr = 8'd5;
        sw(32'h14, 32'hCAFEF00D);
        chk("dbg_pre_store", o_dbg_data, 32'h0);
        idle();
        chk("dbg_post_store", o_dbg_data, 32'hCAFEF00D);
        chk("idle_read_zero", o_read_data, 32'h0);

        // Read and write together: load returns the pre-store word
        op(1'b1, 1'b1, 2'b11, 1'b0, 32'h14, 32'h01020304, 5'd3, 1'b1, 1'b1);
        chk("rw_old", o_read_data, 32'hCAFEF00D);
        ld(2'b11, 1'b0, 32'h14);
        chk("rw_new", o_read_data, 32'h01020304);

        // Upper address bits ignored
        ld(2'b11, 1'b0, 32'h0000_0414);
        chk("addr_wrap", o_read_data, 32'h01020304);

        // Reset during a store: store discarded, memory cleared
        i_rst = 1'b1;
        sw(32'h40, 32'h77777777);
        chk("rst_mid_result", o_result, 32'h0);
        i_rst = 1'b0;
        ld(2'b11, 1'b0, 32'h40);
        chk("rst_store_dropped", o_read_data, 32'h0);
        ld(2'b11, 1'b0, 32'h14);
        chk("rst_mem_cleared", o_read_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
